pipeline_sequencer: RTL

Central stall/flush controller for the 4-stage pipeline (IF, DEC, EXE, WB). Arbitrates between three requesters: the branch unit (decode-stage hold/redirect, execute-stage flush), the load-use hazard detector and the data-memory busy line. Converts their requests into per-register enable and flush strobes plus the PC redirect select. Registered state makes multi-cycle events deterministic: redirect bubbles, load-use bubble, memory wait with a deferred flush.

---
 rtl/core_types_pkg.sv | 40 ++++
 rtl/pipeline_perf_counters.sv | 37 +++
 rtl/pipeline_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/core_types_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states, per-cycle
// action codes and the bundle of stage register strobes.
package core_types_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BUBBLE   = 2'd1,
        REDIRECT = 2'd2,
        MEM_WAIT = 2'd3
    } seq_state_t;

    // What the sequencer decided to do this cycle; the output decode keys off it.
    typedef enum logic [2:0] {
        ACT_NONE     = 3'd0,
        ACT_RESET    = 3'd1,
        ACT_MEM      = 3'd2,
        ACT_FLUSH    = 3'd3,
        ACT_LOADUSE  = 3'd4,
        ACT_HOLD     = 3'd5,
        ACT_REDIR    = 3'd6
    } seq_action_t;

    typedef struct packed {
        logic pc_en;
        logic ifdec_en;
        logic decexe_en;
        logic exewb_en;
        logic ifdec_flush;
        logic decexe_flush;
        logic pc_redirect;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_DEFAULT  = stage_ctrl_t'(7'b1111_000);
    localparam stage_ctrl_t CTRL_RESET    = stage_ctrl_t'(7'b1111_110);
    localparam stage_ctrl_t CTRL_FREEZE   = stage_ctrl_t'(7'b0000_000);
    localparam stage_ctrl_t CTRL_FLUSH    = stage_ctrl_t'(7'b1111_111);
    localparam stage_ctrl_t CTRL_LOADUSE  = stage_ctrl_t'(7'b0011_010);
    localparam stage_ctrl_t CTRL_REDIR    = stage_ctrl_t'(7'b1111_100);

endpackage

// File: rtl/pipeline_perf_counters.sv
// Saturating stall and flush event counters for the pipeline sequencer.
// Only instantiated when PIPELINE_PERF_EN is defined.
module pipeline_perf_counters #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] stall_count_o,
    output logic [CNT_W-1:0] flush_count_o
);

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_i && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush_i && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_count_o = stall_cnt_q;
    assign flush_count_o = flush_cnt_q;

endmodule

// File: rtl/pipeline_sequencer.sv
// Stall/flush controller for the IF/DEC/EXE/WB pipeline.
// Optional performance counters are built when PIPELINE_PERF_EN is defined.
//
// state    | meaning
// RUN      | normal flow, accepts all requests
// BUBBLE   | second cycle of a load-use stall, loadUse ignored
// REDIRECT | fetch refill after an EXE flush, bub_cnt_q cycles remain
// MEM_WAIT | data memory busy, pipeline frozen, flush may be pending
module pipeline_sequencer
    import core_types_pkg::*;
#(
    parameter int unsigned REDIRECT_BUBBLES = 1,
    parameter int unsigned CNT_W            = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             branch_hold_i,
    input  logic             branch_redirect_i,
    input  logic             branch_flush_i,
    input  logic             load_use_i,
    input  logic             mem_busy_i,
    output logic             pc_en_o,
    output logic             ifdec_en_o,
    output logic             decexe_en_o,
    output logic             exewb_en_o,
    output logic             ifdec_flush_o,
    output logic             decexe_flush_o,
    output logic             pc_redirect_o,
    output logic [1:0]       seq_state_o
`ifdef PIPELINE_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_count_o,
    output logic [CNT_W-1:0] flush_count_o
`endif
);

    localparam logic [1:0]  BUB_LOAD    = 2'(REDIRECT_BUBBLES);
    localparam seq_state_t  FLUSH_STATE = (REDIRECT_BUBBLES == 0) ? RUN : REDIRECT;

    if ((REDIRECT_BUBBLES > 3) || (CNT_W < 1)) begin : g_param_check
        $error("pipeline_sequencer: REDIRECT_BUBBLES must be 0..3 and CNT_W >= 1");
    end

    seq_state_t  state_q, state_d;
    logic [1:0]  bub_cnt_q, bub_cnt_d;
    logic        pending_q, pending_d;
    logic        resume_redir_q, resume_redir_d;
    seq_action_t act;
    stage_ctrl_t ctrl;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= RUN;
            bub_cnt_q      <= 2'd0;
            pending_q      <= 1'b0;
            resume_redir_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            bub_cnt_q      <= bub_cnt_d;
            pending_q      <= pending_d;
            resume_redir_q <= resume_redir_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        bub_cnt_d      = bub_cnt_q;
        pending_d      = pending_q;
        resume_redir_d = resume_redir_q;
        act            = ACT_NONE;
        if (rst_i) begin
            state_d        = RUN;
            bub_cnt_d      = 2'd0;
            pending_d      = 1'b0;
            resume_redir_d = 1'b0;
            act            = ACT_RESET;
        end else begin
            case (state_q)
                MEM_WAIT: begin
                    if (mem_busy_i) begin
                        act = ACT_MEM;
                        if (branch_flush_i) pending_d = 1'b1;
                    end else begin
                        pending_d      = 1'b0;
                        resume_redir_d = 1'b0;
                        if (pending_q || branch_flush_i) begin
                            act       = ACT_FLUSH;
                            bub_cnt_d = BUB_LOAD;
                            state_d   = FLUSH_STATE;
                        end else if (resume_redir_q && (bub_cnt_q != 2'd0)) begin
                            // Refill was interrupted; finish it with bub_cnt_q intact.
                            state_d = REDIRECT;
                        end else if (load_use_i) begin
                            act     = ACT_LOADUSE;
                            state_d = BUBBLE;
                        end else begin
                            if (branch_hold_i) act = ACT_HOLD;
                            state_d = RUN;
                        end
                    end
                end
                default: begin
                    if (mem_busy_i) begin
                        act            = ACT_MEM;
                        state_d        = MEM_WAIT;
                        pending_d      = branch_flush_i;
                        resume_redir_d = (state_q == REDIRECT) && (bub_cnt_q != 2'd0);
                    end else if (branch_flush_i) begin
                        act       = ACT_FLUSH;
                        bub_cnt_d = BUB_LOAD;
                        state_d   = FLUSH_STATE;
                    end else if (state_q == REDIRECT) begin
                        act = ACT_REDIR;
                        if (bub_cnt_q != 2'd0) bub_cnt_d = bub_cnt_q - 2'd1;
                        if (bub_cnt_q <= 2'd1) state_d = RUN;
                    end else if (state_q == BUBBLE) begin
                        state_d = RUN;
                    end else if (load_use_i) begin
                        act     = ACT_LOADUSE;
                        state_d = BUBBLE;
                    end else if (branch_hold_i) begin
                        act = ACT_HOLD;
                    end
                end
            endcase
        end
    end

    always_comb begin
        ctrl = CTRL_DEFAULT;
        case (act)
            ACT_RESET:   ctrl = CTRL_RESET;
            ACT_MEM:     ctrl = CTRL_FREEZE;
            ACT_FLUSH:   ctrl = CTRL_FLUSH;
            ACT_LOADUSE: ctrl = CTRL_LOADUSE;
            ACT_REDIR:   ctrl = CTRL_REDIR;
            ACT_HOLD: begin
                ctrl             = CTRL_REDIR;
                ctrl.pc_redirect = branch_redirect_i;
            end
            default:     ctrl = CTRL_DEFAULT;
        endcase
    end

    assign pc_en_o        = ctrl.pc_en;
    assign ifdec_en_o     = ctrl.ifdec_en;
    assign decexe_en_o    = ctrl.decexe_en;
    assign exewb_en_o     = ctrl.exewb_en;
    assign ifdec_flush_o  = ctrl.ifdec_flush;
    assign decexe_flush_o = ctrl.decexe_flush;
    assign pc_redirect_o  = ctrl.pc_redirect;
    assign seq_state_o    = state_q;

`ifdef PIPELINE_PERF_EN
    pipeline_perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .stall_i       (~ctrl.pc_en),
        .flush_i       (act == ACT_FLUSH),
        .stall_count_o (stall_count_o),
        .flush_count_o (flush_count_o)
    );
`else
    // No performance counters in this build.
`endif

endmodule
